y86_fetch_stage: RTL
====================

Name: y86_fetch_stage

Overview:
Fetch stage of the 5-stage Y86-64 pipeline. Holds the F pipeline register (predicted PC) and selects the PC from branch-mispredict and ret feedback. Splits the 10-byte instruction window into fields, computes valP, the predicted next PC and the status code. Drives the f_* bundle that the D pipeline register latches.

Parameters:
RESET_PC, 64'h0, value loaded into F_predPC on reset.
CNT_W, 32, width of the fetched-instruction counter.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
F_stall  in  1  hold F_predPC (from pipeline control).
M_icode  in  4  icode in the M stage.
M_Cnd  in  1  branch condition in the M stage.
M_valA  in  64  fall-through PC carried by jXX in M.
W_icode  in  4  icode in the W stage.
W_valM  in  64  return address loaded by ret in W.
imem_addr  out  64  fetch address (= f_pc).
imem_bytes  in  80  bytes imem[f_pc..f_pc+9]; byte k at bits [8k+7:8k].
imem_error  in  1  address out of range.
f_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
f_icode  out  4  instruction code.
f_ifun  out  4  function code.
f_rA  out  4  register A; 4'hF if absent.
f_rB  out  4  register B; 4'hF if absent.
f_valC  out  64  constant word.
f_valP  out  64  address of the next sequential instruction.
f_predPC  out  64  predicted next PC.
F_predPC  out  64  registered predicted PC (debug/observe).
f_count  out  CNT_W  number of instructions accepted into the pipeline.

Behaviour:
- Sequential state: F_predPC and f_count only. All other outputs are combinational from state and inputs; latency from imem_bytes to f_* is 0 cycles.
- Reset (synchronous, clk edge with reset=1):
  - F_predPC <= RESET_PC.
  - f_count <= 0.
  - Reset overrides F_stall.
  - Reset mid-stream discards any pending mispredict or ret redirect.
- F register on a clk edge with reset=0:
  - F_stall=1: F_predPC holds.
  - F_stall=0: F_predPC <= f_predPC.
- PC select, in priority order:
  1. M_icode==7 && !M_Cnd: f_pc = M_valA.
  2. Else if W_icode==9: f_pc = W_valM.
  3. Else: f_pc = F_predPC.
  - If both conditions hold in the same cycle, the mispredict wins.
  - imem_addr = f_pc.
- Field split:
  - Byte 0: icode = [7:4], ifun = [3:0].
  - If imem_error=1: f_icode=1 (nop), f_ifun=0.
- need_regids when icode ∈ {2,3,4,5,6,A,B}:
  - byte 1 gives rA = [15:12], rB = [11:8].
  - Otherwise rA = rB = 4'hF.
- need_valC when icode ∈ {3,4,5,7,8}:
  - valC is little-endian from bytes 2..9 if need_regids, else bytes 1..8.
  - Otherwise valC = 0.
- valP = f_pc + 1 + need_regids + 8·need_valC. This is a 64-bit add; wrap-around is modulo 2^64 with no flag.
- predPC = valC for icode 7 or 8; otherwise valP.
- instr_valid rules:
  - icode 0,1,3,4,5,8,9,A,B: ifun must be 0.
  - icode 2 and 7: ifun must be 0..6.
  - icode 6: ifun must be 0..3.
  - icode C..F: always invalid.
- f_stat priority: imem_error → ADR; else !instr_valid → INS; else icode==0 → HLT; else AOK.
- Invalid instructions still drive their raw icode/ifun fields.
- f_count increments by 1 on a clk edge when reset=0, F_stall=0 and f_stat==AOK. It wraps at 2^CNT_W.

Test Plan:
- Reset, imem holds irmovq 0x1122334455667788,%rbx (30 F3 88 77 66 55 44 33 22 11) at 0 → f_icode=3, f_rA=F, f_rB=3, f_valC=64'h1122334455667788, f_valP=10, f_stat=1; next edge F_predPC=10, f_count=1.
- call 0x100 (80 00 01 00…) at PC 0x20 → f_valP=0x29, f_predPC=0x100; with F_stall=1 over 3 edges F_predPC stays 0x20 and f_count is unchanged.
- M_icode=7, M_Cnd=0, M_valA=0x40 with W_icode=9 and W_valM=0x80 in the same cycle → imem_addr=0x40; with M_Cnd=1 → imem_addr=0x80.
- Byte 0 = 0x65 (OPq ifun 5) → f_stat=4; byte 0 = 0xC0 → f_stat=4; imem_error=1 → f_icode=1, f_ifun=0, f_stat=3; f_count does not increment in any case.
- halt (00) → f_stat=2, f_valP=pc+1, f_rA=f_rB=F.
- Assert reset while F_predPC=0x55 and a mispredict is present → next edge F_predPC=RESET_PC and f_count=0; F_predPC=64'hFFFF_FFFF_FFFF_FFFF with nop → f_valP=0.

Source files
------------

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: holds the F register, selects the fetch PC from the redirect
// sources, decodes the 10-byte instruction window and drives the f_* bundle.
module y86_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             F_stall,
    input  logic [3:0]       M_icode,
    input  logic             M_Cnd,
    input  logic [63:0]      M_valA,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    output logic [63:0]      imem_addr,
    input  logic [79:0]      imem_bytes,
    input  logic             imem_error,
    output logic [2:0]       f_stat,
    output logic [3:0]       f_icode,
    output logic [3:0]       f_ifun,
    output logic [3:0]       f_rA,
    output logic [3:0]       f_rB,
    output logic [63:0]      f_valC,
    output logic [63:0]      f_valP,
    output logic [63:0]      f_predPC,
    output logic [63:0]      F_predPC,
    output logic [CNT_W-1:0] f_count
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    logic [63:0]      pred_pc_q, pred_pc_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [63:0] f_pc;
    logic        need_regids;
    logic        need_valc;
    logic        instr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_pc_q <= RESET_PC;
            count_q   <= '0;
        end else begin
            pred_pc_q <= pred_pc_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        f_pc        = pred_pc_q;
        f_icode     = imem_bytes[7:4];
        f_ifun      = imem_bytes[3:0];
        need_regids = 1'b0;
        need_valc   = 1'b0;
        instr_valid = 1'b0;
        f_rA        = 4'hF;
        f_rB        = 4'hF;
        f_valC      = 64'h0;
        f_valP      = 64'h0;
        f_predPC    = 64'h0;
        f_stat      = STAT_AOK;

        // A mispredicted jXX in M outranks a ret in W.
        if (M_icode == I_JXX && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end

        if (imem_error) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end

        case (f_icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
            default:                                  need_regids = 1'b0;
        endcase

        case (f_icode)
            4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc = 1'b1;
            default:                      need_valc = 1'b0;
        endcase

        case (f_icode)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA, 4'hB:       instr_valid = (f_ifun == 4'h0);
            4'h2, 4'h7:                   instr_valid = (f_ifun <= 4'h6);
            4'h6:                         instr_valid = (f_ifun <= 4'h3);
            default:                      instr_valid = 1'b0;
        endcase

        if (need_regids) begin
            f_rA = imem_bytes[15:12];
            f_rB = imem_bytes[11:8];
        end

        if (need_valc) begin
            f_valC = need_regids ? imem_bytes[79:16] : imem_bytes[71:8];
        end

        f_valP = f_pc + 64'd1
               + (need_regids ? 64'd1 : 64'd0)
               + (need_valc   ? 64'd8 : 64'd0);

        f_predPC = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;

        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (!instr_valid) begin
            f_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end
    end

    always_comb begin
        pred_pc_d = pred_pc_q;
        count_d   = count_q;
        if (!F_stall) begin
            pred_pc_d = f_predPC;
            if (f_stat == STAT_AOK) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    assign imem_addr = f_pc;
    assign F_predPC  = pred_pc_q;
    assign f_count   = count_q;

endmodule
